// File: rtl/lbp_engine.sv
// Local-binary-pattern engine: walks a raster image in BRAM, builds an 8-neighbour
// LBP code per interior pixel and writes one result word per pixel (borders write 0).
module lbp_engine #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 19,
    parameter int IMG_W      = 300,
    parameter int IMG_H      = 400,
    parameter int CH_WIDTH   = 4,
    parameter int CH_SEL     = 0,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_p,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            cmd,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_valid,
    output logic                  busy,
    output logic                  all_ready
);

    localparam int NUM_CH = DATA_WIDTH / CH_WIDTH;
    localparam int WCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    localparam logic [ADDR_WIDTH-1:0] W_A    = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_P = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [COL_W-1:0]      LAST_C = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]      LAST_R = ROW_W'(IMG_H - 1);
    localparam logic [WCNT_W-1:0]     LAST_W = WCNT_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIX,
        S_BORDER_WR,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_WR,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] p_q, p_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [3:0]            k_q, k_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [CH_WIDTH-1:0]   gc_q, gc_d;
    logic [7:0]            code_q, code_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;

    logic [CH_WIDTH-1:0]   nbr;
    logic                  data_unused;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]            bit_idx;
    logic                  cmp;
    logic                  is_border;
    logic [7:0]            ring;
    logic [7:0]            ring_diff;
    logic [3:0]            trans_cnt;
    logic [3:0]            pop_cnt;
    logic [3:0]            uniform;
    logic [DATA_WIDTH-1:0] result;

    assign nbr         = data_in[CH_SEL*CH_WIDTH +: CH_WIDTH];
    assign data_unused = ^data_in;
    assign bit_idx     = 3'(k_q - 4'd1);
    assign cmp         = (mode_q == 2'd3) ? (nbr > gc_q) : (nbr >= gc_q);
    assign is_border   = (row_q == '0) || (row_q == LAST_R) || (col_q == '0) || (col_q == LAST_C);

    // k=0 reads the centre, k=1..8 read g0..g7 in code-bit order.
    always_comb begin
        case (k_q)
            4'd1:    rd_addr = p_q - W_A - ONE_A;
            4'd2:    rd_addr = p_q - W_A;
            4'd3:    rd_addr = p_q - W_A + ONE_A;
            4'd4:    rd_addr = p_q - ONE_A;
            4'd5:    rd_addr = p_q + ONE_A;
            4'd6:    rd_addr = p_q + W_A - ONE_A;
            4'd7:    rd_addr = p_q + W_A;
            4'd8:    rd_addr = p_q + W_A + ONE_A;
            default: rd_addr = p_q;
        endcase
    end

    // Circular ring g0,g1,g2,g4,g7,g6,g5,g3; ring_diff marks each adjacent-pair change.
    assign ring      = {code_q[3], code_q[5], code_q[6], code_q[7],
                        code_q[4], code_q[2], code_q[1], code_q[0]};
    assign ring_diff = ring ^ {ring[0], ring[7:1]};

    always_comb begin
        // NOTE: blocking '=' here is intentional; the loop accumulates within one evaluation.
        trans_cnt = '0;
        pop_cnt   = '0;
        for (int i = 0; i < 8; i++) begin
            trans_cnt = trans_cnt + 4'(ring_diff[i]);
            pop_cnt   = pop_cnt + 4'(code_q[i]);
        end
    end

    assign uniform = (trans_cnt <= 4'd2) ? pop_cnt : 4'd9;

    always_comb begin
        case (mode_q)
            2'd1:    result = {NUM_CH{code_q[7 -: CH_WIDTH]}};
            2'd2:    result = DATA_WIDTH'(uniform);
            default: result = DATA_WIDTH'(code_q);
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        mode_d       = mode_q;
        p_d          = p_q;
        col_d        = col_q;
        row_d        = row_q;
        k_d          = k_q;
        wcnt_d       = wcnt_q;
        gc_d         = gc_q;
        code_d       = code_q;
        r_addr_d     = r_addr_q;
        output_valid = 1'b0;
        o_addr       = '0;
        data_out     = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d  = cmd;
                    p_d     = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_PIX;
                end
            end
            S_PIX: begin
                code_d  = '0;
                k_d     = '0;
                state_d = is_border ? S_BORDER_WR : S_ISSUE;
            end
            S_ISSUE: begin
                r_addr_d = rd_addr;
                wcnt_d   = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == LAST_W) state_d = S_CAPTURE;
                else                  wcnt_d  = wcnt_q + 1'b1;
            end
            S_CAPTURE: begin
                if (k_q == 4'd0) gc_d = nbr;
                else             code_d[bit_idx] = cmp;
                k_d     = k_q + 4'd1;
                state_d = (k_q == 4'd8) ? S_WR : S_ISSUE;
            end
            S_BORDER_WR, S_WR: begin
                output_valid = 1'b1;
                o_addr       = p_q;
                data_out     = (state_q == S_WR) ? result : '0;
                if (p_q == LAST_P) begin
                    state_d = S_DONE;
                end else begin
                    p_d     = p_q + ONE_A;
                    state_d = S_PIX;
                    if (col_q == LAST_C) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update together.
    always_ff @(posedge clk_p) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            p_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            k_q      <= '0;
            wcnt_q   <= '0;
            gc_q     <= '0;
            code_q   <= '0;
            r_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            p_q      <= p_d;
            col_q    <= col_d;
            row_q    <= row_d;
            k_q      <= k_d;
            wcnt_q   <= wcnt_d;
            gc_q     <= gc_d;
            code_q   <= code_d;
            r_addr_q <= r_addr_d;
        end
    end

    assign r_addr    = r_addr_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign all_ready = (state_q == S_DONE);

endmodule

// File: tb/tb_lbp_engine.sv
// Bench for lbp_engine on a 4x3 image: three instances (latency 1, latency 3, channel 2)
// fed from one image array, checked against a pixel-level LBP model every cycle.
module tb_lbp_engine;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;
    localparam int DW   = 12;
    localparam int AW   = 19;

    logic clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    logic          rst;
    logic [1:0]    cmd;
    logic          start_s  [3];
    logic [AW-1:0] r_addr_w [3];
    logic [DW-1:0] din_w    [3];
    logic [AW-1:0] o_addr_w [3];
    logic [DW-1:0] dout_w   [3];
    logic          ov_w     [3];
    logic          busy_w   [3];
    logic          ar_w     [3];

    logic [DW-1:0] img [NPIX];
    int lat_of   [3] = '{1, 3, 1};
    int chsel_of [3] = '{0, 0, 2};

    lbp_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(W), .IMG_H(H),
                 .CH_WIDTH(4), .CH_SEL(0), .RD_LATENCY(1)) u_dut0 (
        .clk_p(clk_p), .rst(rst), .start(start_s[0]), .cmd(cmd),
        .r_addr(r_addr_w[0]), .data_in(din_w[0]), .o_addr(o_addr_w[0]),
        .data_out(dout_w[0]), .output_valid(ov_w[0]), .busy(busy_w[0]), .all_ready(ar_w[0]));

    lbp_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(W), .IMG_H(H),
                 .CH_WIDTH(4), .CH_SEL(0), .RD_LATENCY(3)) u_dut1 (
        .clk_p(clk_p), .rst(rst), .start(start_s[1]), .cmd(cmd),
        .r_addr(r_addr_w[1]), .data_in(din_w[1]), .o_addr(o_addr_w[1]),
        .data_out(dout_w[1]), .output_valid(ov_w[1]), .busy(busy_w[1]), .all_ready(ar_w[1]));

    lbp_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(W), .IMG_H(H),
                 .CH_WIDTH(4), .CH_SEL(2), .RD_LATENCY(1)) u_dut2 (
        .clk_p(clk_p), .rst(rst), .start(start_s[2]), .cmd(cmd),
        .r_addr(r_addr_w[2]), .data_in(din_w[2]), .o_addr(o_addr_w[2]),
        .data_out(dout_w[2]), .output_valid(ov_w[2]), .busy(busy_w[2]), .all_ready(ar_w[2]));

    // BRAM models: data for an address appears RD_LATENCY cycles after it is presented.
    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        if (a < AW'(NPIX)) return img[a[3:0]];
        return '0;
    endfunction

    logic [DW-1:0] pipe0, pipe2;
    logic [DW-1:0] pipe1 [3];
    always @(posedge clk_p) begin
        pipe0    <= rd(r_addr_w[0]);
        pipe1[0] <= rd(r_addr_w[1]);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
        pipe2    <= rd(r_addr_w[2]);
    end
    assign din_w[0] = pipe0;
    assign din_w[1] = pipe1[2];
    assign din_w[2] = pipe2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] chan(input int p, input int cs);
        logic [DW-1:0] w;
        w = img[p];
        return w[cs*4 +: 4];
    endfunction

    // Pixel-level reference: neighbourhood by (x,y) coordinates, labels from the mode rules.
    function automatic logic [DW-1:0] model_px(input int p, input logic [1:0] mode, input int cs);
        int dx   [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int dy   [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int ring [8] = '{0, 1, 2, 4, 7, 6, 5, 3};
        logic [7:0] code;
        int x, y, gc, nv, trans, ones;
        x = p % W;
        y = p / W;
        if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return '0;
        gc   = int'(chan(p, cs));
        code = '0;
        for (int n = 0; n < 8; n++) begin
            nv = int'(chan((y + dy[n]) * W + x + dx[n], cs));
            code[n] = (mode == 2'd3) ? (nv > gc) : (nv >= gc);
        end
        case (mode)
            2'd1: return {3{code[7:4]}};
            2'd2: begin
                trans = 0;
                ones  = 0;
                for (int n = 0; n < 8; n++) begin
                    if (code[ring[n]] != code[ring[(n + 1) % 8]]) trans++;
                    ones += int'(code[n]);
                end
                return (trans <= 2) ? DW'(ones) : DW'(9);
            end
            default: return DW'(code);
        endcase
    endfunction

    // Scoreboard state per instance.
    int            cyc = 0;
    int            exp_idx   [3];
    bit            exp_on    [3];
    bit            done_pend [3];
    logic [1:0]    frame_cmd [3];
    int            wr_cyc5   [3];
    logic [DW-1:0] res [3][NPIX];

    always @(posedge clk_p) cyc <= cyc + 1;

    always @(negedge clk_p) begin
        for (int i = 0; i < 3; i++) begin
            if (done_pend[i]) begin
                check("all_ready_rise", int'(ar_w[i]), 1);
                check("busy_fall", int'(busy_w[i]), 0);
                done_pend[i] = 1'b0;
            end
            if (ov_w[i]) begin
                if (!exp_on[i]) begin
                    check("no_write_when_idle", int'(ov_w[i]), 0);
                end else begin
                    check("o_addr_order", int'(o_addr_w[i]), exp_idx[i]);
                    check("data_out", int'(dout_w[i]),
                          int'(model_px(exp_idx[i], frame_cmd[i], chsel_of[i])));
                    check("busy_during_write", int'(busy_w[i]), 1);
                    res[i][exp_idx[i]] = dout_w[i];
                    if (exp_idx[i] == 5) wr_cyc5[i] = cyc;
                    if (exp_idx[i] == 6)
                        check("interior_spacing", cyc - wr_cyc5[i], 2 + 9 * (lat_of[i] + 2));
                    exp_idx[i]++;
                    if (exp_idx[i] == NPIX) begin
                        exp_on[i]    = 1'b0;
                        done_pend[i] = 1'b1;
                    end
                end
            end else begin
                check("data_out_idle", int'(dout_w[i]), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic check_zero(input int i);
        check("rst_r_addr", int'(r_addr_w[i]), 0);
        check("rst_o_addr", int'(o_addr_w[i]), 0);
        check("rst_data_out", int'(dout_w[i]), 0);
        check("rst_valid", int'(ov_w[i]), 0);
        check("rst_busy", int'(busy_w[i]), 0);
        check("rst_all_ready", int'(ar_w[i]), 0);
    endtask

    task automatic arm(input int i, input logic [1:0] c);
        cmd          = c;
        frame_cmd[i] = c;
        exp_idx[i]   = 0;
        exp_on[i]    = 1'b1;
        start_s[i]   = 1'b1;
        tick();
        start_s[i]   = 1'b0;
        check("busy_after_start", int'(busy_w[i]), 1);
        check("all_ready_cleared", int'(ar_w[i]), 0);
    endtask

    task automatic run_frame(input int i, input logic [1:0] c, input bit spurious);
        int n;
        arm(i, c);
        if (spurious) begin
            repeat (40) tick();
            cmd        = 2'd1;
            start_s[i] = 1'b1;
            tick();
            start_s[i] = 1'b0;
        end
        n = 0;
        while (!ar_w[i] && n < 2000) begin
            tick();
            n++;
        end
        check("frame_done", int'(ar_w[i]), 1);
        check("write_count", exp_idx[i], NPIX);
    endtask

    initial begin
        rst = 1'b1;
        cmd = 2'd0;
        for (int i = 0; i < 3; i++) begin
            start_s[i]   = 1'b0;
            exp_on[i]    = 1'b0;
            done_pend[i] = 1'b0;
            exp_idx[i]   = 0;
            frame_cmd[i] = 2'd0;
            wr_cyc5[i]   = 0;
        end
        for (int p = 0; p < NPIX; p++) img[p] = '0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) check_zero(i);
        rst = 1'b0;
        tick();

        // Flat image, channel value 5 everywhere.
        for (int p = 0; p < NPIX; p++) img[p] = 12'h555;
        run_frame(0, 2'd0, 1'b0);
        check("flat_c0_p5", int'(res[0][5]), 'h0FF);
        check("flat_c0_p6", int'(res[0][6]), 'h0FF);
        check("flat_c0_p0", int'(res[0][0]), 0);
        check("flat_c0_p11", int'(res[0][11]), 0);
        run_frame(0, 2'd3, 1'b0);
        check("flat_c3_p5", int'(res[0][5]), 'h000);
        check("flat_c3_p6", int'(res[0][6]), 'h000);
        run_frame(0, 2'd1, 1'b0);
        check("flat_c1_p5", int'(res[0][5]), 'hFFF);
        check("flat_c1_p6", int'(res[0][6]), 'hFFF);

        // Ramp image with a start pulse mid-frame that must be ignored.
        for (int p = 0; p < NPIX; p++) img[p] = DW'(p);
        run_frame(0, 2'd0, 1'b1);
        check("ramp_c0_p5", int'(res[0][5]), 'h0F0);
        check("ramp_c0_p6", int'(res[0][6]), 'h0F0);
        repeat (5) begin
            tick();
            check("all_ready_held", int'(ar_w[0]), 1);
        end

        // Same ramp at read latency 3 must give identical results.
        run_frame(1, 2'd0, 1'b0);
        check("lat3_p5", int'(res[1][5]), 'h0F0);
        for (int p = 0; p < NPIX; p++) check("lat_equal", int'(res[1][p]), int'(res[0][p]));

        run_frame(0, 2'd2, 1'b0);
        check("ramp_c2_p5", int'(res[0][5]), 4);

        // Neighbours alternate around p5 to give code 0x55.
        img = '{12'd9, 12'd1, 12'd9, 12'd0, 12'd1, 12'd5, 12'd9, 12'd0, 12'd1, 12'd9, 12'd1, 12'd0};
        run_frame(0, 2'd2, 1'b0);
        check("checker_c2_p5", int'(res[0][5]), 9);

        // Channel 2 holds the ramp, the lower channels hold decoys.
        for (int p = 0; p < NPIX; p++) img[p] = {4'(p), 4'(11 - p), 4'h5};
        run_frame(2, 2'd0, 1'b0);
        check("chsel2_p5", int'(res[2][5]), 'h0F0);
        check("chsel2_p6", int'(res[2][6]), 'h0F0);

        // Reset mid-frame aborts; a fresh start from IDLE completes normally.
        for (int p = 0; p < NPIX; p++) img[p] = DW'(p);
        arm(0, 2'd0);
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        exp_on[0] = 1'b0;
        check_zero(0);
        repeat (100) tick();
        check("abort_no_done", int'(ar_w[0]), 0);
        run_frame(0, 2'd0, 1'b0);
        check("post_rst_p5", int'(res[0][5]), 'h0F0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbp_engine.md
# lbp_engine

Parametrised local-binary-pattern engine. It reads a raster image from the image BRAM, computes an 8-neighbour LBP label for every pixel, and writes one result per pixel into the processing memory. It generalises the team's fixed 300-wide, 4-bit LBP processor with the following additions:

- configurable geometry, channel select and BRAM read latency;
- selectable output modes;
- an explicit start/done handshake;
- defined border output.

## Interface

Parameters:

- DATA_WIDTH, 12, pixel word width (multiple of CH_WIDTH, ≥8)
- ADDR_WIDTH, 19, memory address width
- IMG_W, 300, image width in pixels (≥3)
- IMG_H, 400, image height in pixels (≥3)
- CH_WIDTH, 4, width of one colour channel
- CH_SEL, 0, channel compared; uses data_in[CH_SEL*CH_WIDTH +: CH_WIDTH]
- RD_LATENCY, 1, BRAM read latency in cycles (≥1)

Ports (clock and reset: one clock; reset is synchronous and active-high):

- clk_p  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle frame start request
- cmd  in  2  output mode, sampled at accepted start
- r_addr  out  ADDR_WIDTH  registered read address to image BRAM
- data_in  in  DATA_WIDTH  BRAM read data
- o_addr  out  ADDR_WIDTH  write address to processing memory
- data_out  out  DATA_WIDTH  result pixel
- output_valid  out  1  one-cycle write strobe
- busy  out  1  high from accepted start until frame done
- all_ready  out  1  frame complete; held until next accepted start

## Operation

- **Reset:** every output is 0 and the FSM goes to IDLE. Reset mid-frame aborts the frame; no further writes occur.
- **Start:** start is accepted only in IDLE or DONE. Acceptance latches cmd into mode_r, clears all_ready, sets busy, and sets pixel index p=0. start while busy is ignored.
- **FSM states:** IDLE → (start) → PIX → {BORDER_WR | ISSUE} … → DONE.
  - PIX classifies p. Border pixels are row 0, row IMG_H-1, col 0 and col IMG_W-1; they go to BORDER_WR. All others go to ISSUE with read index k=0.
  - ISSUE loads r_addr with the address for k (k=0 centre p; k=1..8 neighbours g0..g7).
  - WAIT lasts RD_LATENCY cycles.
  - CAPTURE stores the selected channel of data_in:
    - k=0 stores it as gc;
    - otherwise it sets bit g(k-1) = (nbr ≥ gc), or (nbr > gc) when mode_r=3.
    - Then k++. After k=8 the FSM goes to WR; otherwise it returns to ISSUE.
  - WR / BORDER_WR drive o_addr=p, data_out and output_valid=1 for one cycle. If p=IMG_W*IMG_H-1 the FSM goes to DONE; otherwise p++ and the FSM returns to PIX.
  - DONE sets all_ready=1 and busy=0, then waits for start.
- **Neighbour offsets and code bits:** g0 −W−1 (bit0), g1 −W (bit1), g2 −W+1 (bit2), g3 −1 (bit3), g4 +1 (bit4), g5 +W−1 (bit5), g6 +W (bit6), g7 +W+1 (bit7). Address arithmetic is unsigned ADDR_WIDTH and never wraps, because borders are never read.
- **Modes** (code = 8-bit LBP):
  - 0: code zero-extended.
  - 1: code[7:8−CH_WIDTH] replicated into every channel of data_out (grey display).
  - 2: uniform label. Count circular transitions over ring order g0,g1,g2,g4,g7,g6,g5,g3. Output is popcount(code) if transitions ≤2, else 9, zero-extended.
  - 3: strict-greater comparison, code zero-extended.
- **Border output:** data_out = 0 in all modes.
- **Write completeness:** every p in 0..IMG_W*IMG_H−1 is written exactly once, in raster order.
- **Idle outputs:** output_valid=0 and data_out=0 outside WR/BORDER_WR. r_addr holds its last value.

## Timing

- Accepted start at cycle t: busy is high from t+1, and the first PIX is at t+1.
- Border pixel: 2 cycles (PIX, BORDER_WR).
- Interior pixel: 1 + 9·(RD_LATENCY+2) + 1 cycles. This is 29 cycles at RD_LATENCY=1.
- data_in is sampled exactly RD_LATENCY cycles after r_addr takes the new address.
- all_ready rises the cycle after the last output_valid. busy falls in the same cycle.
- start in the same cycle as DONE entry is not accepted; start must arrive while DONE is held.

## Test plan

- **Reset:** pulse rst mid-frame (IMG_W=4, IMG_H=3) → next cycle all outputs 0. No output_valid follows until a new start.
- **Flat image:** IMG_W=4, IMG_H=3, channel value 5 everywhere.
  - cmd=0 → p5 and p6 give 0x0FF; the 10 border pixels give 0.
  - cmd=3 → p5 and p6 give 0x000.
  - cmd=1 → p5 and p6 give 0xFFF.
- **Ramp image:** pixel p value = p (low nibble), IMG_W=4, IMG_H=3.
  - cmd=0 → p5 = 0x0F0 and p6 = 0x0F0.
  - cmd=2 → p5 = 4 (2 transitions).
  - Checkerboard neighbour pattern code 0x55 → label 9.
- **Latency:** repeat the ramp image with RD_LATENCY=1 and RD_LATENCY=3. Results must be identical; interior pixel spacing must be 29 and 47 cycles.
- **Handshake:**
  - start pulsed while busy → ignored; exactly 12 writes, in order o_addr 0..11.
  - all_ready holds until a second start clears it in the cycle after acceptance.
- **Channel select:** CH_SEL=2 with differing nibbles per channel → comparison uses data_in[11:8] only.
